// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: fetches the aligned word pair {pc, pc+4} over an SRAM-like bus
// into a one-entry pair buffer, stalling IF until the pair for the current pc is present.
module inst_fetch_bridge #(
    parameter bit          KSEG_MAP    = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pcn,
    input  logic        if_cln,
    output logic [31:0] if_inst_1,
    output logic [31:0] if_inst_2,
    output logic        delay_hard,
    output logic        IADEE,
    output logic        IADFE,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq0,
        StWait0,
        StReq1,
        StWait1,
        StDrain
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [31:0]       r_tgt_pc;
    logic [31:0]       r_word0;
    logic [31:0]       r_buf0;
    logic [31:0]       r_buf1;
    logic [31:0]       r_buf_pc;
    logic              r_buf_valid;
    logic [CntW-1:0]   r_cnt;
    logic              r_iadfe;

    logic              w_misalign;
    logic              w_hit;
    logic              w_err_hold;
    logic              w_abort;
    logic              w_tmo;
    logic              w_start;
    logic              w_cap0;
    logic              w_cap1;
    logic              w_timeout;
    logic              w_busy;
    logic [31:0]       w_tgt_pc4;

    function automatic logic [31:0] map_addr(input logic [31:0] a);
        return KSEG_MAP ? {3'b000, a[28:0]} : a;
    endfunction

    assign w_misalign = pcn && (pc[1:0] != 2'b00);
    assign w_hit      = r_buf_valid && (r_buf_pc == pc);
    // A timed-out fetch stays reported (and not retried) until pc moves or IF flushes.
    assign w_err_hold = r_iadfe && (pc == r_tgt_pc);
    assign w_abort    = if_cln || (pc != r_tgt_pc);
    assign w_tmo      = (r_cnt == CntW'(TIMEOUT_CYC - 1));
    assign w_tgt_pc4  = r_tgt_pc + 32'd4;
    assign w_busy     = (r_state == StReq0) || (r_state == StWait0) ||
                        (r_state == StReq1) || (r_state == StWait1);

    assign delay_hard = pcn && !w_hit && !w_misalign && !w_err_hold;
    assign IADEE      = w_misalign;
    assign IADFE      = r_iadfe;
    assign if_inst_1  = w_hit ? r_buf0 : 32'h0;
    assign if_inst_2  = w_hit ? r_buf1 : 32'h0;

    always_comb begin
        w_state_d = r_state;
        inst_req  = 1'b0;
        inst_addr = 32'h0;
        w_start   = 1'b0;
        w_cap0    = 1'b0;
        w_cap1    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            StIdle: begin
                if (pcn && !w_hit && !w_misalign && !if_cln && !w_err_hold) begin
                    w_start   = 1'b1;
                    w_state_d = StReq0;
                end
            end
            StReq0: begin
                inst_req  = 1'b1;
                inst_addr = map_addr(r_tgt_pc);
                if (w_abort) begin
                    // Accepted on the abort cycle: its data is still owed to us.
                    w_state_d = (inst_addr_ok && !inst_data_ok) ? StDrain : StIdle;
                end else if (inst_addr_ok) begin
                    if (inst_data_ok) begin
                        w_cap0    = 1'b1;
                        w_state_d = StReq1;
                    end else begin
                        w_state_d = StWait0;
                    end
                end else if (w_tmo) begin
                    w_timeout = 1'b1;
                end
            end
            StWait0: begin
                if (w_abort) begin
                    w_state_d = inst_data_ok ? StIdle : StDrain;
                end else if (inst_data_ok) begin
                    w_cap0    = 1'b1;
                    w_state_d = StReq1;
                end else if (w_tmo) begin
                    w_timeout = 1'b1;
                end
            end
            StReq1: begin
                inst_req  = 1'b1;
                inst_addr = map_addr(w_tgt_pc4);
                if (w_abort) begin
                    w_state_d = (inst_addr_ok && !inst_data_ok) ? StDrain : StIdle;
                end else if (inst_addr_ok) begin
                    if (inst_data_ok) begin
                        w_cap1    = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_state_d = StWait1;
                    end
                end else if (w_tmo) begin
                    w_timeout = 1'b1;
                end
            end
            StWait1: begin
                if (w_abort) begin
                    w_state_d = inst_data_ok ? StIdle : StDrain;
                end else if (inst_data_ok) begin
                    w_cap1    = 1'b1;
                    w_state_d = StIdle;
                end else if (w_tmo) begin
                    w_timeout = 1'b1;
                end
            end
            StDrain: begin
                if (inst_data_ok) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_timeout) begin
            w_state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_tgt_pc    <= 32'h0;
            r_word0     <= 32'h0;
            r_buf0      <= 32'h0;
            r_buf1      <= 32'h0;
            r_buf_pc    <= 32'h0;
            r_buf_valid <= 1'b0;
            r_cnt       <= '0;
            r_iadfe     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_start) begin
                r_tgt_pc <= pc;
                r_cnt    <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + CntW'(1);
            end
            if (w_cap0) begin
                r_word0 <= inst_rdata;
            end
            if (if_cln) begin
                r_buf_valid <= 1'b0;
            end else if (w_cap1) begin
                r_buf0      <= r_word0;
                r_buf1      <= inst_rdata;
                r_buf_pc    <= r_tgt_pc;
                r_buf_valid <= 1'b1;
            end else if (w_timeout) begin
                r_buf_valid <= 1'b0;
            end
            if (w_timeout) begin
                r_iadfe <= 1'b1;
            end else if (if_cln || w_start || (pc != r_tgt_pc)) begin
                r_iadfe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Scoreboard bench for inst_fetch_bridge: random fetch stream against a memory model,
// plus directed flush, misalign, timeout and mid-transaction reset scenarios.
module tb_inst_fetch_bridge;

    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pcn;
    logic        if_cln;
    logic [31:0] if_inst_1;
    logic [31:0] if_inst_2;
    logic        delay_hard;
    logic        IADEE;
    logic        IADFE;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;

    inst_fetch_bridge #(
        .KSEG_MAP    (1'b1),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .pcn          (pcn),
        .if_cln       (if_cln),
        .if_inst_1    (if_inst_1),
        .if_inst_2    (if_inst_2),
        .delay_hard   (delay_hard),
        .IADEE        (IADEE),
        .IADFE        (IADFE),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] i1;
        logic [31:0] i2;
    } exp_t;

    exp_t        exp_q[$];
    int          tx_id   = 0;
    int          seen_id = 0;

    // Bus responder knobs and logs
    int          cyc        = 0;
    int          ad_wait    = -1;
    int          min_ad     = 0;
    int          max_ad     = 0;
    int          min_dg     = 0;
    int          max_dg     = 0;
    bit          no_data    = 1'b0;
    bit          inject     = 1'b0;
    bit          stable_chk = 1'b0;
    int          last_rdy   = 0;
    logic [31:0] pq_addr[$];
    int          pq_rdy[$];
    logic [31:0] acc_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int n);
        checks++;
        errors++;
        $display("FAIL %s: condition not reached within %0d cycles", name, n);
    endtask

    // Physical view of a fetch address, and the word the memory holds there.
    function automatic logic [31:0] map_a(input logic [31:0] a);
        return a & 32'h1FFF_FFFF;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Monitor: the pair is presented when IF is not stalled and no error is flagged.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (!reset && pcn && !delay_hard && !IADEE && !IADFE && tx_id != seen_id) begin
                seen_id = tx_id;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: pair presented with nothing expected");
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_inst1", if_inst_1, e.i1);
                    chk("sb_inst2", if_inst_2, e.i2);
                end
            end
        end
    end

    // Bus responder: in-order reads with random accept and data latencies.
    initial begin
        bit          prev_pend;
        logic [31:0] prev_addr;
        int          rdy;
        prev_pend    = 1'b0;
        prev_addr    = 32'h0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (stable_chk && prev_pend) begin
                chk1("req_held", inst_req, 1'b1);
                chk("addr_held", inst_addr, prev_addr);
            end
            inst_data_ok = 1'b0;
            inst_rdata   = 32'h0;
            if (inject) begin
                inst_data_ok = 1'b1;
                inst_rdata   = 32'hDEAD_BEEF;
            end else if (pq_addr.size() > 0 && pq_rdy[0] <= cyc) begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_word(pq_addr.pop_front());
                void'(pq_rdy.pop_front());
            end
            inst_addr_ok = 1'b0;
            if (inst_req && !reset) begin
                if (ad_wait < 0) ad_wait = int'($urandom_range(max_ad, min_ad));
                if (ad_wait == 0) begin
                    inst_addr_ok = 1'b1;
                    ad_wait      = -1;
                    acc_log.push_back(inst_addr);
                    if (!no_data) begin
                        rdy = cyc + 1 + int'($urandom_range(max_dg, min_dg));
                        if (rdy < last_rdy) rdy = last_rdy;
                        last_rdy = rdy;
                        pq_addr.push_back(inst_addr);
                        pq_rdy.push_back(rdy);
                    end
                end else begin
                    ad_wait--;
                end
            end else begin
                ad_wait = -1;
            end
            prev_pend = inst_req && !inst_addr_ok;
            prev_addr = inst_addr;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        exp_t e;
        pc   = a;
        pcn  = 1'b1;
        e.i1 = mem_word(map_a(a));
        e.i2 = mem_word(map_a(a + 32'd4));
        exp_q.push_back(e);
        tx_id++;
    endtask

    // Wait for the monitor to consume the pair, then hold pc and expect a quiet bridge.
    task automatic await_pair(input logic [31:0] a, input int hold, output int lat);
        int          n;
        bit          bad;
        logic [31:0] s1;
        logic [31:0] s2;
        n = 0;
        while (seen_id != tx_id && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        lat = n;
        if (seen_id != tx_id) begin
            $display("FAIL fetch_wait: pc=%08h no pair presented", a);
            fail_now("fetch_wait", n);
        end
        s1  = if_inst_1;
        s2  = if_inst_2;
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            if (inst_req || delay_hard || if_inst_1 != s1 || if_inst_2 != s2) bad = 1'b1;
        end
        if (hold > 0) chk1("hold_quiet", bad, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] a, input int hold, output int lat);
        step();
        issue(a);
        await_pair(a, hold, lat);
    endtask

    initial begin
        int          lat;
        int          n;
        bit          bad;
        logic [31:0] a;
        logic [31:0] last_pc;

        reset  = 1'b1;
        pc     = 32'h0;
        pcn    = 1'b0;
        if_cln = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk1("rst_req", inst_req, 1'b0);
        chk("rst_addr", inst_addr, 32'h0);
        chk1("rst_delay", delay_hard, 1'b0);
        chk1("rst_iadee", IADEE, 1'b0);
        chk1("rst_iadfe", IADFE, 1'b0);
        chk("rst_inst1", if_inst_1, 32'h0);
        chk("rst_inst2", if_inst_2, 32'h0);

        // Boot fetch with a one-cycle memory
        acc_log.delete();
        fetch(32'hBFC0_0000, 4, lat);
        chk("best_latency", 32'(lat), 32'd6);
        chk("boot_acc_cnt", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() >= 2) begin
            chk("boot_addr0", acc_log[0], 32'h1FC0_0000);
            chk("boot_addr1", acc_log[1], 32'h1FC0_0004);
        end

        // Same pc again: served from the buffer, no bus traffic
        acc_log.delete();
        fetch(32'hBFC0_0000, 6, lat);
        chk("hit_latency", 32'(lat), 32'd1);
        chk("hit_no_bus", 32'(acc_log.size()), 32'd0);

        // Slow address acceptance, then a fully random stream
        stable_chk = 1'b1;
        min_ad     = 3;
        max_ad     = 3;
        max_dg     = 3;
        last_pc    = 32'hBFC0_0000;
        for (int i = 0; i < 6; i++) begin
            a = ($urandom() & 32'h0000_FFFC) | 32'h8000_0000;
            fetch(a, 1, lat);
            last_pc = a;
        end
        min_ad = 0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(9, 0))
                0:       a = last_pc;
                1:       a = 32'hFFFF_FFFC;
                2:       a = 32'hBFC0_0000 | ($urandom() & 32'h000F_FFFC);
                default: a = $urandom() & 32'hFFFF_FFFC;
            endcase
            fetch(a, int'($urandom_range(3, 0)), lat);
            last_pc = a;
        end
        stable_chk = 1'b0;

        // Flush with a valid pair for the held pc invalidates the buffer
        min_ad = 0;
        max_ad = 0;
        min_dg = 3;
        max_dg = 3;
        acc_log.delete();
        step();
        if_cln = 1'b1;
        step();
        if_cln = 1'b0;
        @(negedge clk);
        #1;
        chk1("flush_inval", delay_hard, 1'b1);
        // Flush while the second word is outstanding; the late data must be dropped
        n = 0;
        while (acc_log.size() < 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (acc_log.size() < 2) fail_now("refetch_wait1", n);
        step();
        if_cln = 1'b1;
        issue(32'h8000_2000);
        step();
        if_cln = 1'b0;
        await_pair(32'h8000_2000, 2, lat);
        min_dg = 0;
        max_dg = 0;

        // Misaligned fetch
        acc_log.delete();
        step();
        pc = 32'hBFC0_0002;
        @(negedge clk);
        #1;
        chk1("mis_iadee", IADEE, 1'b1);
        chk1("mis_delay", delay_hard, 1'b0);
        chk("mis_inst1", if_inst_1, 32'h0);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (inst_req) bad = 1'b1;
        end
        chk1("mis_no_req", bad, 1'b0);
        chk("mis_no_acc", 32'(acc_log.size()), 32'd0);

        // Bus timeout: address accepted, data never returns
        no_data = 1'b1;
        acc_log.delete();
        step();
        pc = 32'h8000_0380;
        n  = 0;
        while (!inst_req && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!inst_req) fail_now("tmo_req", n);
        n = 0;
        while (!IADFE && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'(TMO));
        chk1("tmo_req_off", inst_req, 1'b0);
        chk1("tmo_delay", delay_hard, 1'b0);
        chk("tmo_inst1", if_inst_1, 32'h0);
        if (acc_log.size() > 0) chk("kseg0_addr", acc_log[0], 32'h0000_0380);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (inst_req || !IADFE) bad = 1'b1;
        end
        chk1("tmo_hold", bad, 1'b0);
        no_data = 1'b0;
        fetch(32'h8000_0400, 1, lat);
        chk1("tmo_cleared", IADFE, 1'b0);

        // Reset in the middle of a request; a stray data_ok afterwards is ignored
        no_data = 1'b1;
        min_ad  = 10;
        max_ad  = 10;
        step();
        pc = 32'h0000_1000;
        n  = 0;
        while (!inst_req && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!inst_req) fail_now("rst_mid_req", n);
        #1;
        reset = 1'b1;
        #1;
        chk1("rst_mid_req_drop", inst_req, 1'b0);
        chk("rst_mid_addr", inst_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        pcn     = 1'b0;
        no_data = 1'b0;
        min_ad  = 0;
        max_ad  = 2;
        inject  = 1'b1;
        step();
        inject = 1'b0;
        @(negedge clk);
        #1;
        chk1("stray_delay", delay_hard, 1'b0);
        chk("stray_inst1", if_inst_1, 32'h0);
        fetch(32'h0000_1000, 2, lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
